ovc_credit_manager: RTL and testbench
=====================================

Name: ovc_credit_manager

Overview:
- Output-port side of the credit-based flow-control loop; one instance per router output port.
- Allocates downstream (output) virtual channels to head/single flits from the input VCs.
- Tracks per-OVC credits: decrements when a flit departs, increments when the downstream VC returns a credit.
- Drives the per-OVC credit-available bit consumed as input VC credit C, and releases an OVC once its packet has fully drained downstream.

Parameters:
- NUM_VC, 4, number of output VCs on this port.
- VC_SIZE, 16, downstream VC buffer depth; this is the initial and maximum credit count.
- CNT_W, 5, credit counter width; must satisfy 2^CNT_W > VC_SIZE.
- VC_W, 2, OVC index width (clog2 NUM_VC).
- HEADER_LEN, 2, flit type field width.
- HEAD_FLIT, 2'b01 / BODY_FLIT, 2'b10 / TAIL_FLIT, 2'b11 / SINGLE_FLIT, 2'b00, flit type encodings.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- alloc_req  in  1  an input VC holding a head/single flit requests an OVC.
- alloc_gnt  out  1  combinational; OVC granted this cycle.
- alloc_vc  out  VC_W  index of the granted OVC; valid when alloc_gnt=1.
- send_valid  in  1  a flit leaves on an OVC this cycle.
- send_vc  in  VC_W  OVC of the departing flit.
- send_type  in  HEADER_LEN  type field of the departing flit.
- credit_in  in  NUM_VC  one bit per OVC; each bit set returns 1 credit that cycle.
- credit_avail  out  NUM_VC  bit i = (cnt[i] != 0) and state[i]==ACTIVE; registered-state derived.
- credit_cnt  out  NUM_VC*CNT_W  per-OVC counters; OVC i occupies bits [i*CNT_W +: CNT_W].
- vc_idle  out  NUM_VC  state[i]==IDLE.
- err_underflow  out  1  sticky error flag.
- err_overflow  out  1  sticky error flag.
- err_proto  out  1  sticky error flag.

Behaviour:
- Reset (async, active-high) values:
  - all states IDLE; all counters VC_SIZE.
  - round-robin pointer 0; all error flags 0.
  - outputs: alloc_gnt=0, credit_avail=0, vc_idle=all 1s.
- Per-OVC state machine (IDLE, ACTIVE, DRAINING):
  - IDLE -> ACTIVE: on the clock edge where this OVC is granted.
  - ACTIVE -> DRAINING: on an edge with send_valid, send_vc=i and send_type TAIL or SINGLE.
  - DRAINING -> IDLE: on an edge where the next counter value equals VC_SIZE (downstream VC empty). This can coincide with the final credit return.
- Allocation:
  - alloc_gnt = alloc_req & (any state==IDLE); same-cycle combinational grant.
  - Winner is the first IDLE OVC at or after the pointer, scanning upward modulo NUM_VC.
  - On a grant, the pointer becomes winner+1 (mod NUM_VC). With no grant, the pointer holds.
  - At most one grant per cycle.
  - An OVC entering IDLE on an edge is grantable from the next cycle, not the same cycle.
- Credit counter, per OVC, next = cnt - dec + inc:
  - dec = send_valid & send_vc==i.
  - inc = credit_in[i].
  - Send and credit on the same OVC in the same cycle leaves the count unchanged.
- Error conditions:
  - Send with cnt==0 and no same-cycle credit: set err_underflow; no decrement (saturate at 0).
  - Credit with cnt==VC_SIZE and no same-cycle send: set err_overflow; no increment (saturate at VC_SIZE).
  - Send on an OVC not in ACTIVE (including one granted in the same cycle): set err_proto; counter and state unchanged.
- Flags are sticky until rst.
- Latency:
  - Counter, state and credit_avail update on the edge after the event.
  - A flit sent while cnt==1 drops credit_avail the following cycle. Upstream must not also send in that cycle, consistent with C being sampled from registered state.
- Reset mid-packet: immediately restores all OVCs to IDLE with full credits. Any in-flight credit_in is then seen as overflow only if the count is already VC_SIZE.

Test Plan:
- Reset then 4 consecutive alloc_req cycles -> alloc_vc 0,1,2,3 with alloc_gnt=1 each; a 5th request -> alloc_gnt=0; vc_idle=4'b0000.
- OVC0 ACTIVE, send 16 flits with no credits -> credit_cnt[0] steps 16..0; credit_avail[0]=0 after the 16th. A 17th send -> err_underflow=1, count stays 0.
- OVC1 ACTIVE, cnt=10, send and credit_in[1] together for 5 cycles -> count stays 10, no error.
- OVC2 sends HEAD, BODY, TAIL (cnt 13) -> DRAINING; vc_idle[2]=0 until 3 credits return; IDLE on the edge cnt reaches 16; granted again only the cycle after.
- All OVCs IDLE, credit_in[3] pulse -> err_overflow=1, count stays 16. Separately, send on an IDLE OVC -> err_proto=1.
- Assert rst asynchronously mid-packet (no clock edge) -> states IDLE and counts 16 immediately; flags cleared; pointer 0 (next grant is OVC0).

Source files
------------

// File: rtl/ovc_credit_manager.sv
// ovc_credit_manager: output-port credit bookkeeping for one router output port.
// It allocates output VCs to head/single flits with a round-robin scan. It keeps
// one credit counter per OVC and walks each OVC through IDLE -> ACTIVE -> DRAINING.
// An OVC is released once all of its credits have come back from downstream.
module ovc_credit_manager #(
  parameter int NUM_VC     = 4,
  parameter int VC_SIZE    = 16,
  parameter int CNT_W      = 5,
  parameter int VC_W       = 2,
  parameter int HEADER_LEN = 2,
  parameter logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b01,
  parameter logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b10,
  parameter logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b11,
  parameter logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b00
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_req,
  output logic                    alloc_gnt,
  output logic [VC_W-1:0]         alloc_vc,
  input  logic                    send_valid,
  input  logic [VC_W-1:0]         send_vc,
  input  logic [HEADER_LEN-1:0]   send_type,
  input  logic [NUM_VC-1:0]       credit_in,
  output logic [NUM_VC-1:0]       credit_avail,
  output logic [NUM_VC*CNT_W-1:0] credit_cnt,
  output logic [NUM_VC-1:0]       vc_idle,
  output logic                    err_underflow,
  output logic                    err_overflow,
  output logic                    err_proto
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(VC_SIZE);

  logic [VC_W-1:0]   r_ptr;
  logic              r_err_uf;
  logic              r_err_of;
  logic              r_err_pr;

  logic [NUM_VC-1:0] w_idle;
  logic [NUM_VC-1:0] w_uf;
  logic [NUM_VC-1:0] w_of;
  logic [NUM_VC-1:0] w_send_bad;
  logic              w_ends_pkt;
  logic              w_found;
  logic [VC_W-1:0]   w_winner;
  logic [VC_W-1:0]   w_ptr_next;

  // Classify the departing flit: tail and single flits close the packet on their OVC.
  always_comb begin
    w_ends_pkt = 1'b0;
    case (send_type)
      TAIL_FLIT, SINGLE_FLIT: w_ends_pkt = 1'b1;
      HEAD_FLIT, BODY_FLIT:   w_ends_pkt = 1'b0;
      default:                w_ends_pkt = 1'b0;
    endcase
  end

  // Round-robin scan: first IDLE OVC at or after the pointer, wrapping modulo NUM_VC.
  always_comb begin
    int unsigned idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = (int'(r_ptr) + k) % NUM_VC;
      if (!w_found && w_idle[idx]) begin
        w_found  = 1'b1;
        w_winner = VC_W'(idx);
      end
    end
  end

  assign alloc_gnt  = alloc_req & w_found;
  assign alloc_vc   = w_winner;
  assign w_ptr_next = VC_W'((int'(w_winner) + 1) % NUM_VC);

  // The pointer moves past the winner only when a grant is actually issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (alloc_gnt) begin
      r_ptr <= w_ptr_next;
    end
  end

  // Error flags are sticky and only reset can clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_uf <= 1'b0;
      r_err_of <= 1'b0;
      r_err_pr <= 1'b0;
    end else begin
      if (|w_uf)       r_err_uf <= 1'b1;
      if (|w_of)       r_err_of <= 1'b1;
      if (|w_send_bad) r_err_pr <= 1'b1;
    end
  end

  assign err_underflow = r_err_uf;
  assign err_overflow  = r_err_of;
  assign err_proto     = r_err_pr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_ovc
      logic [1:0]       r_state;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_next;
      logic             w_hit;
      logic             w_send_ok;
      logic             w_grant;
      logic             w_uf_i;
      logic             w_of_i;

      // A send only counts when the OVC is ACTIVE. An OVC granted this same
      // cycle is still IDLE here, so a send on it is flagged as a protocol error.
      assign w_hit          = send_valid && (send_vc == VC_W'(gi));
      assign w_send_ok      = w_hit && (r_state == ST_ACTIVE);
      assign w_send_bad[gi] = w_hit && (r_state != ST_ACTIVE);
      assign w_grant        = alloc_gnt && (w_winner == VC_W'(gi));

      // Next credit count: a send and a credit in the same cycle cancel out.
      // Otherwise the count saturates at 0 and at VC_SIZE, and the error is flagged.
      always_comb begin
        w_cnt_next = r_cnt;
        w_uf_i     = 1'b0;
        w_of_i     = 1'b0;
        if (w_send_ok && !credit_in[gi]) begin
          if (r_cnt == '0) w_uf_i = 1'b1;
          else             w_cnt_next = r_cnt - 1'b1;
        end else if (!w_send_ok && credit_in[gi]) begin
          if (r_cnt == CNT_FULL) w_of_i = 1'b1;
          else                   w_cnt_next = r_cnt + 1'b1;
        end
      end

      assign w_uf[gi] = w_uf_i;
      assign w_of[gi] = w_of_i;

      // Credit counter register; full credits after reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= CNT_FULL;
        else     r_cnt <= w_cnt_next;
      end

      // OVC lifecycle. The OVC leaves DRAINING when the downstream buffer is
      // empty, which can happen on the same edge as the final credit return.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= ST_IDLE;
        end else begin
          case (r_state)
            ST_IDLE:   if (w_grant) r_state <= ST_ACTIVE;
            ST_ACTIVE: if (w_send_ok && w_ends_pkt) r_state <= ST_DRAIN;
            ST_DRAIN:  if (w_cnt_next == CNT_FULL) r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
          endcase
        end
      end

      assign w_idle[gi]       = (r_state == ST_IDLE);
      assign vc_idle[gi]      = w_idle[gi];
      assign credit_avail[gi] = (r_cnt != '0) && (r_state == ST_ACTIVE);
      assign credit_cnt[gi*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate

endmodule

// File: tb/tb_ovc_credit_manager.sv
// Bench for ovc_credit_manager. Directed vectors are paired with a high-level
// model of OVC ownership and credits. The model is checked against the DUT every cycle.
module tb_ovc_credit_manager;
  localparam int NV = 4;
  localparam int CW = 5;
  localparam int VS = 16;
  localparam logic [1:0] HEAD = 2'b01, BODY = 2'b10, TAIL = 2'b11;
  localparam int M_IDLE = 0, M_ACTIVE = 1, M_DRAIN = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           alloc_req;
  logic           alloc_gnt;
  logic [1:0]     alloc_vc;
  logic           send_valid;
  logic [1:0]     send_vc;
  logic [1:0]     send_type;
  logic [NV-1:0]  credit_in;
  logic [NV-1:0]  credit_avail;
  logic [NV*CW-1:0] credit_cnt;
  logic [NV-1:0]  vc_idle;
  logic           err_underflow;
  logic           err_overflow;
  logic           err_proto;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns each OVC, how many downstream slots are free, and the sticky errors.
  int m_cnt [NV];
  int m_st  [NV];
  int m_ptr;
  bit m_uf, m_of, m_pr;

  ovc_credit_manager dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_vc(alloc_vc),
    .send_valid(send_valid), .send_vc(send_vc), .send_type(send_type),
    .credit_in(credit_in), .credit_avail(credit_avail), .credit_cnt(credit_cnt),
    .vc_idle(vc_idle), .err_underflow(err_underflow), .err_overflow(err_overflow),
    .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt_of(input int i);
    return credit_cnt[i*CW +: CW];
  endfunction

  function automatic int m_winner();
    for (int k = 0; k < NV; k++) begin
      if (m_st[(m_ptr + k) % NV] == M_IDLE) return (m_ptr + k) % NV;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_cnt[i] = VS;
      m_st[i]  = M_IDLE;
    end
    m_ptr = 0;
    m_uf = 0; m_of = 0; m_pr = 0;
  endtask

  // Apply one clock edge worth of events to the model.
  task automatic model_update();
    int  w;
    bit  g;
    if (rst) begin
      model_reset();
      return;
    end
    w = m_winner();
    g = alloc_req && (w >= 0);
    for (int i = 0; i < NV; i++) begin
      bit hit, legal, inc;
      int nc;
      hit   = send_valid && (send_vc == i);
      legal = hit && (m_st[i] == M_ACTIVE);
      inc   = credit_in[i];
      nc    = m_cnt[i];
      if (hit && !legal) m_pr = 1;
      if (legal && !inc) begin
        if (nc == 0) m_uf = 1; else nc = nc - 1;
      end else if (!legal && inc) begin
        if (nc == VS) m_of = 1; else nc = nc + 1;
      end
      if (m_st[i] == M_IDLE && g && w == i) m_st[i] = M_ACTIVE;
      else if (m_st[i] == M_ACTIVE && legal && (send_type == TAIL || send_type == 2'b00)) m_st[i] = M_DRAIN;
      else if (m_st[i] == M_DRAIN && nc == VS) m_st[i] = M_IDLE;
      m_cnt[i] = nc;
    end
    if (g) m_ptr = (w + 1) % NV;
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    int w;
    logic [NV-1:0]    ea, ei;
    logic [NV*CW-1:0] ec;
    w = m_winner();
    check("cyc_gnt", alloc_gnt, (alloc_req && w >= 0));
    if (alloc_req && w >= 0) check("cyc_vc", alloc_vc, w);
    for (int i = 0; i < NV; i++) begin
      ea[i] = (m_st[i] == M_ACTIVE) && (m_cnt[i] != 0);
      ei[i] = (m_st[i] == M_IDLE);
      ec[i*CW +: CW] = CW'(m_cnt[i]);
    end
    check("cyc_avail", credit_avail, ea);
    check("cyc_idle", vc_idle, ei);
    check("cyc_cnt", credit_cnt, ec);
    check("cyc_err", {err_underflow, err_overflow, err_proto}, {m_uf, m_of, m_pr});
  end

  task automatic drive(input logic req, input logic sv, input logic [1:0] vc,
                       input logic [1:0] ty, input logic [NV-1:0] cr);
    alloc_req  = req;
    send_valid = sv;
    send_vc    = vc;
    send_type  = ty;
    credit_in  = cr;
    $display("[TB] t=%0t req=%0b send=%0b vc=%0d type=%0b credit=%b", $time, req, sv, vc, ty, cr);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, BODY, 4'b0000);
  endtask

  initial begin
    rst = 1'b1;
    alloc_req = 0; send_valid = 0; send_vc = 0; send_type = BODY; credit_in = 0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    idle();
    check("rst_idle", vc_idle, 4'hF);
    check("rst_avail", credit_avail, 4'h0);
    check("rst_gnt", alloc_gnt, 1'b0);
    check("rst_cnt", credit_cnt, 20'h84210);
    tick();

    // Four back-to-back requests take OVCs 0..3; a fifth finds nothing free.
    for (int k = 0; k < NV; k++) begin
      drive(1'b1, 1'b0, 2'd0, BODY, 4'b0000);
      check("alloc_gnt", alloc_gnt, 1'b1);
      check("alloc_vc", alloc_vc, k);
      tick();
    end
    drive(1'b1, 1'b0, 2'd0, BODY, 4'b0000);
    check("alloc_full_gnt", alloc_gnt, 1'b0);
    check("alloc_full_idle", vc_idle, 4'h0);
    tick();

    // Drain OVC0's credits to zero, then overrun it once.
    for (int k = 0; k < VS; k++) begin
      drive(1'b0, 1'b1, 2'd0, BODY, 4'b0000);
      check("ovc0_step", cnt_of(0), VS - k);
      tick();
    end
    idle();
    check("ovc0_zero", cnt_of(0), 0);
    check("ovc0_avail", credit_avail[0], 1'b0);
    check("ovc0_no_uf", err_underflow, 1'b0);
    drive(1'b0, 1'b1, 2'd0, BODY, 4'b0000);
    tick();
    idle();
    check("uf_flag", err_underflow, 1'b1);
    check("uf_sat", cnt_of(0), 0);

    // OVC1 at 10 credits with sends matched by returns stays at 10.
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 2'd1, BODY, 4'b0000);
      tick();
    end
    idle();
    check("ovc1_ten", cnt_of(1), 10);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 2'd1, BODY, 4'b0010);
      tick();
      idle();
      check("ovc1_hold", cnt_of(1), 10);
    end
    check("ovc1_no_err", {err_overflow, err_proto}, 2'b00);

    // OVC2 sends a 3-flit packet, drains, and is reallocated only once idle.
    drive(1'b0, 1'b1, 2'd2, HEAD, 4'b0000); tick();
    drive(1'b0, 1'b1, 2'd2, BODY, 4'b0000); tick();
    drive(1'b0, 1'b1, 2'd2, TAIL, 4'b0000); tick();
    idle();
    check("ovc2_cnt13", cnt_of(2), 13);
    check("ovc2_busy", vc_idle[2], 1'b0);
    check("ovc2_drain_avail", credit_avail[2], 1'b0);
    drive(1'b0, 1'b0, 2'd0, BODY, 4'b0100); tick();
    drive(1'b0, 1'b0, 2'd0, BODY, 4'b0100); tick();
    idle();
    check("ovc2_cnt15", cnt_of(2), 15);
    check("ovc2_still_busy", vc_idle[2], 1'b0);
    drive(1'b1, 1'b0, 2'd0, BODY, 4'b0100);
    check("ovc2_no_early_gnt", alloc_gnt, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'd0, BODY, 4'b0000);
    check("ovc2_idle", vc_idle[2], 1'b1);
    check("ovc2_full", cnt_of(2), VS);
    check("ovc2_regnt", alloc_gnt, 1'b1);
    check("ovc2_regnt_vc", alloc_vc, 2);
    tick();

    // Asynchronous reset in the middle of a packet on OVC3.
    drive(1'b0, 1'b1, 2'd3, HEAD, 4'b0000);
    tick();
    idle();
    check("pre_rst_cnt3", cnt_of(3), 15);
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_idle", vc_idle, 4'hF);
    check("arst_cnt", credit_cnt, 20'h84210);
    check("arst_flags", {err_underflow, err_overflow, err_proto}, 3'b000);
    tick();
    rst = 1'b0;

    // Overflow on an idle OVC, then a send on an idle OVC.
    drive(1'b0, 1'b0, 2'd0, BODY, 4'b1000);
    tick();
    idle();
    check("of_flag", err_overflow, 1'b1);
    check("of_sat", cnt_of(3), VS);
    drive(1'b0, 1'b1, 2'd1, BODY, 4'b0000);
    tick();
    idle();
    check("pr_flag", err_proto, 1'b1);
    check("pr_cnt", cnt_of(1), VS);
    check("pr_idle", vc_idle, 4'hF);
    drive(1'b1, 1'b0, 2'd0, BODY, 4'b0000);
    check("ptr_reset_gnt", alloc_gnt, 1'b1);
    check("ptr_reset_vc", alloc_vc, 0);
    tick();
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
